// File: rtl/otp_pad_engine.sv
// otp_pad_engine: LFSR one-time-pad stream engine with a burn-after-use pad store.
module otp_pad_engine #(
  parameter int                DATA_W    = 8,
  parameter int                PAD_DEPTH = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  localparam int               IDX_W     = $clog2(PAD_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              zeroize,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic [IDX_W:0]    pad_count,
  output logic              pad_full
);
  logic [DATA_W-1:0]    pad_mem [PAD_DEPTH];
  logic [PAD_DEPTH-1:0] live;
  logic [IDX_W-1:0]     wr_ptr;
  logic [LFSR_W-1:0]    lfsr;
  logic                 can_load, acc, enc, dec, hit;
  logic [DATA_W-1:0]    pad;
  assign can_load = !out_valid | out_ready;
  // encrypts stall on a live write slot; decrypts never do
  assign in_ready = rst_n & can_load & !zeroize & (in_mode | !live[wr_ptr]);
  assign acc      = in_valid & in_ready;
  assign enc      = acc & !in_mode;
  assign dec      = acc & in_mode;
  assign hit      = live[in_idx];
  assign pad      = lfsr[DATA_W-1:0];
  assign pad_full = pad_count == (IDX_W+1)'(PAD_DEPTH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
      pad_count <= '0;
      wr_ptr    <= '0;
      lfsr      <= SEED;
      live      <= '0;
      for (int i = 0; i < PAD_DEPTH; i++) pad_mem[i] <= '0;
    end else if (zeroize) begin
      out_valid <= 1'b0;
      pad_count <= '0;
      wr_ptr    <= '0;
      lfsr      <= SEED;
      live      <= '0;
      for (int i = 0; i < PAD_DEPTH; i++) pad_mem[i] <= '0;
    end else begin
      out_valid <= acc ? 1'b1 : (out_ready ? 1'b0 : out_valid);
      if (enc) begin
        pad_mem[wr_ptr] <= pad;
        live[wr_ptr]    <= 1'b1;
        out_data        <= in_data ^ pad;
        out_idx         <= wr_ptr;
        out_err         <= 1'b0;
        wr_ptr          <= wr_ptr + IDX_W'(1);
        lfsr            <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        pad_count       <= pad_count + (IDX_W+1)'(1);
      end
      if (dec) begin
        out_idx  <= in_idx;
        out_err  <= !hit;
        out_data <= hit ? in_data ^ pad_mem[in_idx] : '0;
        if (hit) begin
          live[in_idx]    <= 1'b0;
          pad_mem[in_idx] <= '0;
          pad_count       <= pad_count - (IDX_W+1)'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_otp_pad_engine.sv
// tb_otp_pad_engine: directed + random ops against a slot-map scoreboard of live pads.
module tb_otp_pad_engine;
  logic       clk = 0, rst_n = 0, zeroize = 0, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic [2:0] in_idx = 0;
  logic       in_ready, out_valid, out_err, pad_full;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic [3:0] pad_count;
  int total = 0, bad = 0;
  bit [15:0] mlfsr;
  int        mwr;
  int        store[int];
  bit        exp_ov, exp_oe, last_rdy;
  bit [7:0]  exp_od;
  int        exp_oi;

  otp_pad_engine dut (
    .clk(clk), .rst_n(rst_n), .zeroize(zeroize), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .in_idx(in_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_err(out_err),
    .pad_count(pad_count), .pad_full(pad_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    store.delete();
    mwr = 0;
    mlfsr = 16'hACE1;
    exp_ov = 0;
  endtask

  task automatic op(input bit v, input bit m, input bit [7:0] d, input bit [2:0] k,
                    input bit ordy, input bit z = 0);
    bit er;
    in_valid = v; in_mode = m; in_data = d; in_idx = k; out_ready = ordy; zeroize = z;
    #1;
    er = (!exp_ov || ordy) && !z && (m || !store.exists(mwr));
    last_rdy = in_ready;
    check("in_ready", in_ready, er);
    @(posedge clk); #1;
    if (z) reset_model();
    else if (v && er) begin
      exp_ov = 1;
      if (!m) begin
        store[mwr] = mlfsr[7:0];
        exp_od = d ^ mlfsr[7:0]; exp_oi = mwr; exp_oe = 0;
        mwr = (mwr + 1) % 8;
        mlfsr = (mlfsr >> 1) ^ (mlfsr[0] ? 16'hB400 : 16'h0);
      end else if (store.exists(k)) begin
        exp_od = d ^ 8'(store[k]); exp_oi = k; exp_oe = 0;
        store.delete(k);
      end else begin
        exp_od = 0; exp_oi = k; exp_oe = 1;
      end
    end else if (ordy) exp_ov = 0;
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check("out_data", out_data, exp_od);
      check("out_idx", out_idx, exp_oi);
      check("out_err", out_err, exp_oe);
    end
    check("pad_count", pad_count, store.num());
    check("pad_full", pad_full, store.num() == 8);
  endtask

  task automatic scenario1();
    op(1, 0, 8'h00, 0, 1);
    check("s1_data0", out_data, 8'hE1);
    check("s1_idx0", out_idx, 0);
    check("s1_cnt", pad_count, 1);
    op(1, 0, 8'h00, 0, 1);
    check("s1_data1", out_data, 8'h70);
    check("s1_idx1", out_idx, 1);
  endtask

  initial begin
    reset_model();
    #2;
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_count", pad_count, 0);
    @(posedge clk); #1;
    rst_n = 1;
    scenario1();
    op(0, 0, 0, 0, 1, 1);
    op(1, 0, 8'h5A, 0, 1);
    check("s2_enc", out_data, 8'hBB);
    op(1, 1, 8'hBB, 0, 1);
    check("s2_dec", out_data, 8'h5A);
    check("s2_err", out_err, 0);
    check("s2_cnt", pad_count, 0);
    op(1, 1, 8'hBB, 0, 1);
    check("s2_burn_data", out_data, 0);
    check("s2_burn_err", out_err, 1);
    op(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 8'($urandom), 0, 1);
      check("s3_idx", out_idx, i);
    end
    check("s3_full", pad_full, 1);
    check("s3_cnt", pad_count, 8);
    op(1, 0, 8'h11, 0, 1);
    check("s3_stall", last_rdy, 0);
    op(1, 1, 8'h22, 3, 1);
    check("s3_dec3_err", out_err, 0);
    op(1, 0, 8'h33, 0, 1);
    check("s3_stall2", last_rdy, 0);
    op(1, 1, 8'h44, 0, 1);
    op(1, 0, 8'h55, 0, 1);
    check("s3_resume_rdy", last_rdy, 1);
    check("s3_resume_idx", out_idx, 0);
    op(0, 0, 0, 0, 1, 1);
    op(1, 0, 8'h66, 0, 1);
    repeat (5) op(1, 0, 8'h77, 0, 0);
    op(1, 0, 8'h88, 0, 1);
    check("s4_drain_acc", last_rdy, 1);
    check("s4_valid", out_valid, 1);
    check("s4_idx", out_idx, 1);
    op(0, 0, 0, 0, 1, 1);
    repeat (3) op(1, 0, 8'($urandom), 0, 1);
    op(1, 0, 8'h99, 0, 1, 1);
    check("s5_valid", out_valid, 0);
    check("s5_cnt", pad_count, 0);
    op(1, 0, 8'h00, 0, 1);
    check("s5_data", out_data, 8'hE1);
    check("s5_idx", out_idx, 0);
    op(1, 1, 8'h00, 1, 1);
    check("s5_err", out_err, 1);
    repeat (400)
      op($urandom_range(0, 3) != 0, $urandom_range(0, 1), 8'($urandom), 3'($urandom),
         $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    op(0, 0, 0, 0, 1, 1);
    op(1, 0, 8'hA5, 0, 0);
    check("s6_pre_valid", out_valid, 1);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("s6_valid", out_valid, 0);
    check("s6_data", out_data, 0);
    check("s6_idx", out_idx, 0);
    check("s6_err", out_err, 0);
    check("s6_cnt", pad_count, 0);
    check("s6_full", pad_full, 0);
    check("s6_ready", in_ready, 0);
    reset_model();
    @(posedge clk); #1;
    rst_n = 1;
    scenario1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
